// File: rtl/pipeline_control_if.sv
// Bundle between the ID-stage hazard sequencer and the pipeline/MULT-DIV logic it steers.
// The slave modport is the sequencer's view; master is the pipeline side.
interface pipeline_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       RS_ID;
    logic [4:0]       RT_ID;
    logic [4:0]       RT_EX;
    logic             MemRead_EX;
    logic             MulDiv_ID;
    logic             HiLo_ID;
    logic             Jump_ID;
    logic             BranchTaken_EX;
    logic             CountClear;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXBubble;
    logic             MulDivStart;
    logic             MulDivBusy;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output RS_ID, RT_ID, RT_EX, MemRead_EX, MulDiv_ID, HiLo_ID, Jump_ID, BranchTaken_EX,
               CountClear,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivStart, MulDivBusy, StallCount,
               FlushCount
    );

    modport slave (
        input  RS_ID, RT_ID, RT_EX, MemRead_EX, MulDiv_ID, HiLo_ID, Jump_ID, BranchTaken_EX,
               CountClear,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivStart, MulDivBusy, StallCount,
               FlushCount
    );
endinterface

// File: rtl/pipeline_control.sv
// Prioritised stall/flush sequencer: load-use, MULT/DIV occupancy and control-transfer flushes,
// with saturating stall/flush counters for performance debug.
module pipeline_control #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 16
) (
    input logic               clk,
    input logic               reset,
    pipeline_control_if.slave ctl
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [7:0] CntLoad = 8'(MULDIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic loaduse, mdstall, stall, busy, start;
    logic pc_write, ifid_write, ifid_flush, idex_bubble;

    always_comb begin
        loaduse = ctl.MemRead_EX && (ctl.RT_EX != 5'd0) &&
                  ((ctl.RT_EX == ctl.RS_ID) || (ctl.RT_EX == ctl.RT_ID));
        busy    = (state_q == StBusy);
        mdstall = busy && (ctl.MulDiv_ID || ctl.HiLo_ID);
        stall   = loaduse || mdstall;
        // A load-use in the same cycle defers the start until the load has moved on.
        start   = !busy && ctl.MulDiv_ID && !ctl.BranchTaken_EX && !loaduse;
    end

    // A taken branch squashes ID, so it overrides any stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (ctl.BranchTaken_EX) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (ctl.Jump_ID) begin
            ifid_flush  = 1'b1;
        end
    end

    // The MULT/DIV is older than any branch, so BUSY is never aborted by a flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                    cnt_d   = CntLoad;
                end
            end
            StBusy: begin
                if (cnt_q == 8'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctl.CountClear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && !ctl.BranchTaken_EX && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (ifid_flush && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctl.PCWrite     = pc_write;
    assign ctl.IFIDWrite   = ifid_write;
    assign ctl.IFIDFlush   = ifid_flush;
    assign ctl.IDEXBubble  = idex_bubble;
    assign ctl.MulDivStart = start;
    assign ctl.MulDivBusy  = busy;
    assign ctl.StallCount  = stall_cnt_q;
    assign ctl.FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Scenario bench for pipeline_control with a 4-cycle MULT/DIV and 4-bit counters.
// Each cycle's expected outputs are queued when stimulus is driven and popped at the negedge.
module tb_pipeline_control;

    localparam int unsigned Cycles = 4;
    localparam int unsigned CntW   = 4;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivStart, MulDivBusy}
    localparam logic [5:0] Norm       = 6'b110000;
    localparam logic [5:0] Stall      = 6'b000100;
    localparam logic [5:0] Start      = 6'b110010;
    localparam logic [5:0] Busy       = 6'b110001;
    localparam logic [5:0] StallBusy  = 6'b000101;
    localparam logic [5:0] Branch     = 6'b111100;
    localparam logic [5:0] BranchBusy = 6'b111101;
    localparam logic [5:0] Jump       = 6'b111000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pipeline_control_if #(.CNT_W(CntW)) bus ();

    pipeline_control #(
        .MULDIV_CYCLES(Cycles),
        .CNT_W        (CntW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ctl  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mem;
        logic [4:0] rtex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md;
        logic       hl;
        logic       jmp;
        logic       br;
        logic       clr;
        logic [5:0] ctrl;
    } stim_t;

    typedef struct {
        string       name;
        logic [13:0] val;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_sc   = 4'd0;
    logic [3:0] m_fc   = 4'd0;

    function automatic stim_t mk(input logic mem, input logic [4:0] rtex, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic md, input logic hl,
                                 input logic jmp, input logic br, input logic clr,
                                 input logic [5:0] ctrl);
        stim_t s;
        s.mem = mem; s.rtex = rtex; s.rs = rs; s.rt = rt; s.md = md; s.hl = hl;
        s.jmp = jmp; s.br = br; s.clr = clr; s.ctrl = ctrl;
        return s;
    endfunction

    function automatic stim_t quiet(input logic [5:0] ctrl);
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctrl);
    endfunction

    function automatic logic [3:0] sat(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

    function automatic logic [13:0] observed();
        return {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXBubble, bus.MulDivStart,
                bus.MulDivBusy, bus.StallCount, bus.FlushCount};
    endfunction

    task automatic drive(input stim_t s);
        bus.MemRead_EX     = s.mem;
        bus.RT_EX          = s.rtex;
        bus.RS_ID          = s.rs;
        bus.RT_ID          = s.rt;
        bus.MulDiv_ID      = s.md;
        bus.HiLo_ID        = s.hl;
        bus.Jump_ID        = s.jmp;
        bus.BranchTaken_EX = s.br;
        bus.CountClear     = s.clr;
    endtask

    // Drive one cycle, queue its expectation, advance the counter model, wait for the sample point.
    task automatic step(input stim_t s, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        e.name = name;
        e.val  = {s.ctrl, m_sc, m_fc};
        sb.push_back(e);
        if (s.clr) begin
            m_sc = 4'd0;
            m_fc = 4'd0;
        end else begin
            if (!s.ctrl[5]) m_sc = sat(m_sc);
            if (s.ctrl[3])  m_fc = sat(m_fc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            bus.RS_ID = 5'($urandom); bus.RT_ID = 5'($urandom); bus.RT_EX = 5'($urandom);
            bus.MemRead_EX = 1'b0; bus.MulDiv_ID = 1'($urandom); bus.HiLo_ID = 1'($urandom);
            bus.Jump_ID = 1'($urandom); bus.BranchTaken_EX = 1'($urandom);
            bus.CountClear = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.PCWrite, bus.IFIDWrite, bus.MulDivBusy} !== 3'b110 ||
                bus.StallCount !== 4'd0 || bus.FlushCount !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got pc/ifid/busy=%b sc=%0d fc=%0d want 110 0 0",
                         i, {bus.PCWrite, bus.IFIDWrite, bus.MulDivBusy}, bus.StallCount,
                         bus.FlushCount);
            end
        end
        drive(quiet(Norm));
        #1;
        checks++;
        if (observed() !== {Norm, 8'h00}) begin
            errors++;
            $display("FAIL reset_quiet: got %b want %b", observed(), {Norm, 8'h00});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== {Norm, 8'h00}) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", observed(), {Norm, 8'h00});
        end
        m_sc = 4'd0;
        m_fc = 4'd0;
    endtask

    task automatic test_load_use();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Stall));
        t.push_back(quiet(Norm));
        t.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Norm));
        t.push_back(mk(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Stall));
        t.push_back(mk(1'b1, 5'd5, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Norm));
        t.push_back(mk(1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Norm));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("load_use[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_mult_mfhi();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Start));
        for (int i = 0; i < 4; i++) begin
            t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, StallBusy));
        end
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, Norm));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("mult_mfhi[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    // Branch mid-BUSY keeps the unit busy; a MULT held at the BUSY->IDLE edge starts one cycle later.
    task automatic test_branch_busy();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Start));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, StallBusy));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, BranchBusy));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, StallBusy));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, StallBusy));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Start));
        for (int i = 0; i < 4; i++) t.push_back(quiet(Busy));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("branch_busy[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_deferred_start();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Stall));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Start));
        for (int i = 0; i < 4; i++) t.push_back(quiet(Busy));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("deferred_start[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_branch_stall();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, Branch));
        t.push_back(quiet(Norm));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, Branch));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("branch_stall[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_jump();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Stall));
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Jump));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("jump[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Start));
        t.push_back(quiet(Busy));
        foreach (t[i]) begin
            step(t[i], $sformatf("mid_busy[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (observed() !== {Norm, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", observed(), {Norm, 8'h00});
        end
        m_sc = 4'd0;
        m_fc = 4'd0;
        #1;
        reset = 1'b1;
        step(quiet(Norm), "after_async_reset");
        e = sb.pop_front();
        checks++;
        if (observed() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
        end
    endtask

    task automatic test_saturation();
        stim_t t[$];
        exp_t  e;
        for (int i = 0; i < 20; i++) begin
            t.push_back(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Stall));
        end
        t.push_back(quiet(Norm));
        t.push_back(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, Stall));
        t.push_back(quiet(Norm));
        t.push_back(mk(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Stall));
        t.push_back(quiet(Norm));
        foreach (t[i]) begin
            step(t[i], $sformatf("saturation[%0d]", i));
            e = sb.pop_front();
            checks++;
            if (observed() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b want %b", e.name, observed(), e.val);
            end
        end
    endtask

    initial begin
        drive(quiet(Norm));
        test_reset();
        test_load_use();
        test_mult_mfhi();
        test_branch_busy();
        test_deferred_start();
        test_branch_stall();
        test_jump();
        test_reset_mid_busy();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the five-stage pipeline. It merges load-use hazard detection, multi-cycle MULT/DIV occupancy tracking and control-transfer flushing into one prioritised set of pipeline-register enables. It also keeps saturating stall and flush counters for performance debug. It sits beside the ID stage and drives the PC, IF/ID and ID/EX register controls and the start strobe of the MULT/DIV unit.

## Interface
- MULDIV_CYCLES, 32, cycles the MULT/DIV unit stays busy after a start (legal range 2..255)
- CNT_W, 16, width of each performance counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- RS_ID  input  5  rs field of the instruction in ID
- RT_ID  input  5  rt field of the instruction in ID
- RT_EX  input  5  destination rt of the instruction in EX
- MemRead_EX  input  1  instruction in EX is a load
- MulDiv_ID  input  1  instruction in ID is MULT/MULTU/DIV/DIVU
- HiLo_ID  input  1  instruction in ID is MFHI/MFLO
- Jump_ID  input  1  jump resolved in ID; decoder never asserts it together with MulDiv_ID
- BranchTaken_EX  input  1  taken branch resolved in EX
- CountClear  input  1  synchronous clear of both counters
- PCWrite  output  1  PC load enable
- IFIDWrite  output  1  IF/ID load enable
- IFIDFlush  output  1  IF/ID is cleared to NOP
- IDEXBubble  output  1  zero ID/EX control signals
- MulDivStart  output  1  single-cycle start to the MULT/DIV unit
- MulDivBusy  output  1  the FSM is in BUSY
- StallCount  output  CNT_W  number of stall cycles, saturating
- FlushCount  output  CNT_W  number of IF/ID flush cycles, saturating

## Operation
- Internal conditions, evaluated combinationally:
  - loaduse = MemRead_EX & (RT_EX != 0) & (RT_EX == RS_ID | RT_EX == RT_ID)
  - mdstall = BUSY & (MulDiv_ID | HiLo_ID)
  - stall = loaduse | mdstall
- Priority 1, BranchTaken_EX: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1, MulDivStart=0. Any stall is overridden because the ID instruction is squashed.
- Priority 2, stall: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1, MulDivStart=0.
- Priority 3, Jump_ID: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=0.
- Otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- MulDivStart = IDLE & MulDiv_ID & !BranchTaken_EX & !loaduse.
- The FSM has two states, IDLE and BUSY, plus an 8-bit down-counter `cnt`:
  - IDLE -> BUSY when MulDivStart=1; `cnt` is loaded with MULDIV_CYCLES-1.
  - In BUSY, `cnt` decrements each cycle. BUSY -> IDLE on the edge where `cnt`==0.
  - BranchTaken_EX does not abort BUSY, because the MULT/DIV is older than the branch.
- MulDivBusy = (state == BUSY).
- StallCount increments on every cycle with stall=1 and no BranchTaken_EX.
- FlushCount increments on every cycle with IFIDFlush=1.
- Both counters saturate at 2^CNT_W-1, with no wrap.
- CountClear=1 zeroes both counters on the next edge and takes precedence over an increment in the same cycle.

## Timing
- While reset=0:
  - state=IDLE, `cnt`=0, StallCount=0, FlushCount=0, taking effect immediately (asynchronous).
  - Outputs with all inputs 0: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, MulDivStart=0, MulDivBusy=0.
- Reset asserted mid-BUSY returns the FSM to IDLE at once. MulDivBusy falls without waiting for an edge.
- All enable/flush/bubble outputs are combinational from inputs and state, with zero-cycle latency.
- MULT/DIV occupancy, with start asserted in cycle T:
  - MulDivBusy=1 in cycles T+1 .. T+MULDIV_CYCLES.
  - A dependent MFHI/MFLO or second MULT/DIV in ID stalls through cycle T+MULDIV_CYCLES.
  - It is released in cycle T+MULDIV_CYCLES+1.
- Load-use with no other hazard stalls for exactly one cycle. The load advances to MEM, so the condition drops on the next cycle.
- When a load-use hazard and MulDiv_ID occur together in IDLE, the start is deferred until the cycle after the load-use clears.
- On the edge where BUSY ends, a MulDiv_ID held in ID is not started in that cycle. It starts in the following IDLE cycle.

## Test plan
- Reset: hold reset=0 with random inputs -> PCWrite=1, IFIDWrite=1, MulDivBusy=0, counters 0. Release reset -> no outputs change until inputs change.
- Load-use: MemRead_EX=1, RT_EX=8, RS_ID=8 for 1 cycle -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly 1 cycle; StallCount=1. Repeat with RT_EX=0 -> no stall.
- MULT then MFHI, MULDIV_CYCLES=4:
  - Start in cycle 10 -> MulDivStart=1 in cycle 10 only; MulDivBusy=1 in cycles 11..14.
  - MFHI in ID from cycle 11 -> stalled in cycles 11..14, released in cycle 15; StallCount=4.
- Branch during stall: loaduse=1 and BranchTaken_EX=1 in the same cycle -> PCWrite=1, IFIDFlush=1, IDEXBubble=1; StallCount unchanged; FlushCount+1.
- Branch during BUSY: BranchTaken_EX=1 at cycle 12 of the previous scenario -> MulDivBusy stays 1 through cycle 14.
- Jump versus stall: Jump_ID=1 with loaduse=1 -> stall wins (IFIDFlush=0). Next cycle with Jump_ID=1 -> IFIDFlush=1, PCWrite=1.
- Saturation and clear, CNT_W=4: 20 stall cycles -> StallCount=15. CountClear=1 together with a stall -> StallCount=0 on the next edge.
